// File: rtl/ch_cfg_pkg.sv
// Shared types and constants for the channel configuration sequencer.
package ch_cfg_pkg;

  localparam int unsigned CLK_FEQ = 50_000_000;
  localparam int unsigned PARAM_W = 16;

  typedef logic [PARAM_W-1:0] param_t;

  localparam logic [1:0] REG_FEQ   = 2'd0;
  localparam logic [1:0] REG_SCL   = 2'd1;
  localparam logic [1:0] REG_DUTY  = 2'd2;
  localparam logic [1:0] REG_DELAY = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VALIDATE,
    ST_HOLD,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef struct packed {
    param_t feq;
    param_t scl;
    param_t duty;
    param_t delay;
  } ch_param_t;

endpackage

// File: rtl/ch_cfg_check.sv
// Combinational legality check for one channel's parameter set.
module ch_cfg_check
  import ch_cfg_pkg::*;
(
  input  param_t feq_i,
  input  param_t scl_i,
  input  param_t duty_i,
  input  param_t delay_i,
  output logic   pass_o
);

  logic [PARAM_W:0] span_c;

  // Delay plus duty must still fit in one period counter.
  assign span_c = {1'b0, delay_i} + {1'b0, duty_i};

  assign pass_o = (feq_i != '0) && (scl_i != '0) && (scl_i >= feq_i) && !span_c[PARAM_W];

endmodule

// File: rtl/ch_config_sequencer.sv
// Host register front-end: shadow writes, then validate/hold/load/release
// of the masked channels on each commit.
module ch_config_sequencer
  import ch_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter param_t      DEF_FEQ     = 16'd1000,
  parameter param_t      DEF_SCL     = 16'd10000
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(NUM_CH)+1:0]   wr_addr,
  input  logic [15:0]                 wr_data,
  input  logic                        commit_valid,
  output logic                        commit_ready,
  input  logic [NUM_CH-1:0]           commit_mask,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [$clog2(NUM_CH)-1:0]   err_ch,
  output logic [16*NUM_CH-1:0]        ch_sub_clk_feq,
  output logic [16*NUM_CH-1:0]        ch_sub_clk_scl,
  output logic [16*NUM_CH-1:0]        ch_duty_cycle,
  output logic [16*NUM_CH-1:0]        ch_delay_set,
  output logic [NUM_CH-1:0]           ch_rstn
);

  localparam int unsigned CH_W      = $clog2(NUM_CH);
  localparam int unsigned HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CH_W-1:0]   LAST_IDX  = CH_W'(NUM_CH - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);
  localparam ch_param_t RST_PARAM = {DEF_FEQ, DEF_SCL, 16'd0, 16'd0};

  state_e              state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                fail_q, fail_d;
  logic [CH_W-1:0]     fail_ch_q, fail_ch_d;
  logic [CH_W-1:0]     err_ch_q, err_ch_d;
  logic [NUM_CH-1:0]   ch_rstn_q, rstn_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                load_c;

  ch_param_t           shadow_q [NUM_CH];
  ch_param_t           active_q [NUM_CH];
  ch_param_t           sel_c;
  logic                pass_c;

  logic                wr_fire_c;
  logic                commit_fire_c;
  logic [CH_W-1:0]     wr_ch_c;
  logic [1:0]          wr_reg_c;

  assign wr_ready      = (state_q == ST_IDLE);
  assign commit_ready  = (state_q == ST_IDLE);
  assign wr_fire_c     = wr_valid & wr_ready;
  assign commit_fire_c = commit_valid & commit_ready;
  assign wr_ch_c       = wr_addr[CH_W+1:2];
  assign wr_reg_c      = wr_addr[1:0];

  assign sel_c = shadow_q[idx_q];

  ch_cfg_check u_check (
    .feq_i   (sel_c.feq),
    .scl_i   (sel_c.scl),
    .duty_i  (sel_c.duty),
    .delay_i (sel_c.delay),
    .pass_o  (pass_c)
  );

  always_ff @(posedge clk or negedge rstn) begin : p_state
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    mask_d    = mask_q;
    fail_d    = fail_q;
    fail_ch_d = fail_ch_q;
    err_ch_d  = err_ch_q;
    rstn_d    = ch_rstn_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_fire_c) begin
          state_d = ST_VALIDATE;
          mask_d  = commit_mask;
          idx_d   = '0;
          fail_d  = 1'b0;
        end
      end
      ST_VALIDATE: begin
        idx_d = idx_q + CH_W'(1);
        // Only the first failure is kept so err_ch reports the lowest channel.
        if (mask_q[idx_q] && !pass_c && !fail_q) begin
          fail_d    = 1'b1;
          fail_ch_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          if (fail_d) begin
            state_d  = ST_ERR;
            err_d    = 1'b1;
            err_ch_d = fail_ch_d;
          end else begin
            state_d = ST_HOLD;
            load_c  = 1'b1;
            rstn_d  = ch_rstn_q & ~mask_q;
            hold_d  = '0;
          end
        end
      end
      ST_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == LAST_HOLD) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          rstn_d  = ch_rstn_q | mask_q;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin : p_regs
    if (!rstn) begin
      idx_q     <= '0;
      hold_q    <= '0;
      mask_q    <= '0;
      fail_q    <= 1'b0;
      fail_ch_q <= '0;
      err_ch_q  <= '0;
      ch_rstn_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      fail_q    <= fail_d;
      fail_ch_q <= fail_ch_d;
      err_ch_q  <= err_ch_d;
      ch_rstn_q <= rstn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Host writes land only while idle; unknown channel indices match nothing.
  always_ff @(posedge clk or negedge rstn) begin : p_shadow
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= RST_PARAM;
    end else if (wr_fire_c) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch_c == CH_W'(c)) begin
          unique case (wr_reg_c)
            REG_FEQ:   shadow_q[c].feq   <= wr_data;
            REG_SCL:   shadow_q[c].scl   <= wr_data;
            REG_DUTY:  shadow_q[c].duty  <= wr_data;
            REG_DELAY: shadow_q[c].delay <= wr_data;
            default:   shadow_q[c]       <= shadow_q[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : p_active
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) active_q[c] <= RST_PARAM;
    end else if (load_c) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask_q[c]) active_q[c] <= shadow_q[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign ch_sub_clk_feq[16*c +: 16] = active_q[c].feq;
    assign ch_sub_clk_scl[16*c +: 16] = active_q[c].scl;
    assign ch_duty_cycle[16*c +: 16]  = active_q[c].duty;
    assign ch_delay_set[16*c +: 16]   = active_q[c].delay;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_ch  = err_ch_q;
  assign ch_rstn = ch_rstn_q;

endmodule

// File: tb/tb_ch_config_sequencer.sv
// Randomized and directed bench for ch_config_sequencer against a
// commit-timeline reference model.
module tb_ch_config_sequencer;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned HOLD   = 2;
  localparam int unsigned AW     = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr = '0;
  logic [15:0]       wr_data = '0;
  logic              commit_valid = 1'b0;
  logic              commit_ready;
  logic [NUM_CH-1:0] commit_mask = '0;
  logic              busy, done, err;
  logic [1:0]        err_ch;
  logic [63:0]       ch_sub_clk_feq, ch_sub_clk_scl, ch_duty_cycle, ch_delay_set;
  logic [NUM_CH-1:0] ch_rstn;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  ch_config_sequencer #(
    .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .DEF_FEQ(16'd1000), .DEF_SCL(16'd10000)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_mask(commit_mask),
    .busy(busy), .done(done), .err(err), .err_ch(err_ch),
    .ch_sub_clk_feq(ch_sub_clk_feq), .ch_sub_clk_scl(ch_sub_clk_scl),
    .ch_duty_cycle(ch_duty_cycle), .ch_delay_set(ch_delay_set),
    .ch_rstn(ch_rstn)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: [channel][reg] with reg 0=feq 1=scl 2=duty 3=delay.
  logic [15:0]       m_sh  [NUM_CH][4];
  logic [15:0]       m_act [NUM_CH][4];
  logic [NUM_CH-1:0] m_rstn, m_mask;
  logic [1:0]        m_err_ch, m_fch;
  bit                m_idle, m_done, m_err, m_ok;
  int                m_rel;

  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh[c][0] = 16'd1000; m_sh[c][1] = 16'd10000; m_sh[c][2] = '0; m_sh[c][3] = '0;
      m_act[c] = m_sh[c];
    end
    m_rstn = '0; m_mask = '0; m_err_ch = '0; m_fch = '0;
    m_idle = 1'b1; m_done = 1'b0; m_err = 1'b0; m_ok = 1'b1; m_rel = 0;
  endfunction

  function automatic bit ch_ok(input int k);
    int unsigned span;
    span = 32'(m_sh[k][3]) + 32'(m_sh[k][2]);
    return (m_sh[k][0] != 0) && (m_sh[k][1] != 0) && (m_sh[k][1] >= m_sh[k][0]) && (span <= 32'hFFFF);
  endfunction

  // After accept edge (rel 0), edge rel=r opens cycle T+r+1.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_reset();
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_idle) begin
        if (wr_valid) m_sh[wr_addr[3:2]][wr_addr[1:0]] = wr_data;
        if (commit_valid) begin
          m_idle = 1'b0; m_rel = 0; m_mask = commit_mask; m_ok = 1'b1;
          for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m_mask[k] && !ch_ok(k)) begin m_ok = 1'b0; m_fch = 2'(k); end
          end
        end
      end else begin
        m_rel++;
        if (m_ok) begin
          if (m_rel == NUM_CH) begin
            for (int c = 0; c < NUM_CH; c++) if (m_mask[c]) m_act[c] = m_sh[c];
            m_rstn = m_rstn & ~m_mask;
          end
          if (m_rel == NUM_CH + HOLD) begin m_rstn = m_rstn | m_mask; m_done = 1'b1; end
          if (m_rel == NUM_CH + HOLD + 1) m_idle = 1'b1;
        end else begin
          if (m_rel == NUM_CH) begin m_err = 1'b1; m_err_ch = m_fch; end
          if (m_rel == NUM_CH + 1) m_idle = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e_feq, e_scl, e_duty, e_dly;
    if (rstn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        e_feq[16*c +: 16] = m_act[c][0]; e_scl[16*c +: 16] = m_act[c][1];
        e_duty[16*c +: 16] = m_act[c][2]; e_dly[16*c +: 16] = m_act[c][3];
      end
      chk("wr_ready", 64'(wr_ready), 64'(m_idle));
      chk("commit_ready", 64'(commit_ready), 64'(m_idle));
      chk("busy", 64'(busy), 64'(!m_idle));
      chk("done", 64'(done), 64'(m_done));
      chk("err", 64'(err), 64'(m_err));
      chk("err_ch", 64'(err_ch), 64'(m_err_ch));
      chk("ch_rstn", 64'(ch_rstn), 64'(m_rstn));
      chk("feq", ch_sub_clk_feq, e_feq);
      chk("scl", ch_sub_clk_scl, e_scl);
      chk("duty", ch_duty_cycle, e_duty);
      chk("delay", ch_delay_set, e_dly);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int ch, input int rg, input int d);
    wr_valid = 1'b1; wr_addr = AW'(ch * 4 + rg); wr_data = 16'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic commit(input logic [NUM_CH-1:0] m);
    commit_valid = 1'b1; commit_mask = m;
    tick();
    commit_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    int rg;
    #25;
    chk("rst_ch_rstn", 64'(ch_rstn), 64'h0);
    chk("rst_feq0", 64'(ch_sub_clk_feq[15:0]), 64'd1000);
    chk("rst_scl0", 64'(ch_sub_clk_scl[15:0]), 64'd10000);
    chk("rst_busy", 64'(busy), 64'h0);
    tick();
    rstn = 1'b1;
    tick();

    // Good commit on ch1: hold at T+5..T+6, done at T+7.
    wr(1, 0, 100); wr(1, 1, 1000); wr(1, 2, 3); wr(1, 3, 2);
    commit(4'b0010);
    for (int j = 1; j <= 8; j++) begin
      if (j > 1) tick();
      chk("t2_done", 64'(done), 64'(j == 7));
      if (j == 4) chk("t2_feq_before", 64'(ch_sub_clk_feq[31:16]), 64'd1000);
      if (j == 5 || j == 6) chk("t2_rstn_hold", 64'(ch_rstn), 64'h0);
      if (j == 5) chk("t2_feq1", 64'(ch_sub_clk_feq[31:16]), 64'd100);
      if (j == 5) chk("t2_duty1", 64'(ch_duty_cycle[31:16]), 64'd3);
      if (j == 7) chk("t2_rstn_rel", 64'(ch_rstn), 64'h2);
    end

    // Rejected commit: ch2 scl < feq, ch3 feq = 0; lowest failure is ch2.
    wr(2, 1, 50); wr(3, 0, 0);
    commit(4'b1100);
    for (int j = 1; j <= 6; j++) begin
      if (j > 1) tick();
      chk("t3_err", 64'(err), 64'(j == 5));
      if (j == 5) chk("t3_err_ch", 64'(err_ch), 64'd2);
      if (j == 5) chk("t3_rstn", 64'(ch_rstn), 64'h2);
      if (j == 6) chk("t3_scl2", 64'(ch_sub_clk_scl[47:32]), 64'd10000);
    end

    // Same-cycle write and commit: the new value is the one committed.
    wr_valid = 1'b1; wr_addr = AW'(0); wr_data = 16'd500;
    commit(4'b0001);
    wr_valid = 1'b0;
    repeat (7) tick();
    chk("t4_feq0", 64'(ch_sub_clk_feq[15:0]), 64'd500);

    // Write held through busy is taken only once idle again.
    commit(4'b0001);
    wr_valid = 1'b1; wr_addr = AW'(2); wr_data = 16'd9;
    repeat (10) tick();
    wr_valid = 1'b0;
    chk("t5_duty_old", 64'(ch_duty_cycle[15:0]), 64'd0);
    commit(4'b0001);
    repeat (7) tick();
    chk("t5_duty_new", 64'(ch_duty_cycle[15:0]), 64'd9);

    // Empty mask still completes.
    commit(4'b0000);
    for (int j = 1; j <= 8; j++) begin
      if (j > 1) tick();
      chk("t6_done", 64'(done), 64'(j == 7));
      chk("t6_rstn", 64'(ch_rstn), 64'h3);
    end

    // Reset in the middle of HOLD.
    commit(4'b0001);
    repeat (4) tick();
    chk("t7_in_hold", 64'(ch_rstn), 64'h2);
    #3 rstn = 1'b0;
    #1;
    chk("t7_rstn", 64'(ch_rstn), 64'h0);
    chk("t7_busy", 64'(busy), 64'h0);
    chk("t7_ready", 64'(wr_ready), 64'h1);
    chk("t7_feq0", 64'(ch_sub_clk_feq[15:0]), 64'd1000);
    chk("t7_feq1", 64'(ch_sub_clk_feq[31:16]), 64'd1000);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      rg = int'($urandom_range(0, 3));
      case (rg)
        0: d = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
        1: d = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 20000));
        default: d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40000))
                                                 : 16'($urandom_range(0, 100));
      endcase
      wr_valid     = 1'($urandom_range(0, 1));
      wr_addr      = AW'(int'($urandom_range(0, NUM_CH - 1)) * 4 + rg);
      wr_data      = d;
      commit_valid = ($urandom_range(0, 7) == 0);
      commit_mask  = NUM_CH'($urandom_range(0, 15));
      tick();
    end
    wr_valid = 1'b0;
    commit_valid = 1'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ch_config_sequencer.md
# ch_config_sequencer

Register front-end and update sequencer for a bank of `ch_output_module` pulse channels. Accepts host register writes into per-channel shadow registers, then applies them on a commit command. Each commit validates the masked channels, holds them in reset, loads the active parameters and releases them, so every updated channel restarts its period cleanly. Sits between the host/command decoder and the channel output bank.

## Interface
- `NUM_CH`, 4: number of channels (2–8).
- `HOLD_CYCLES`, 2: cycles `ch_rstn` is held low per commit (≥1).
- `DEF_FEQ`, 16'd1000: reset value of `sub_clk_feq` shadow and active registers.
- `DEF_SCL`, 16'd10000: reset value of `sub_clk_scl` shadow and active registers.
- `clk`  in  1  system clock (50 MHz).
- `rstn`  in  1  reset; asynchronous, active-low.
- `wr_valid`  in  1  register write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`.
- `wr_addr`  in  $clog2(NUM_CH)+2  {channel, reg}; reg 0=feq, 1=scl, 2=duty, 3=delay.
- `wr_data`  in  16  write data.
- `commit_valid`  in  1  commit request.
- `commit_ready`  out  1  commit accepted when `commit_valid & commit_ready`.
- `commit_mask`  in  NUM_CH  channels to update, sampled at accept.
- `busy`  out  1  sequencer not in IDLE.
- `done`  out  1  one-cycle pulse when a commit completes successfully.
- `err`  out  1  one-cycle pulse when a commit is rejected.
- `err_ch`  out  $clog2(NUM_CH)  lowest failing channel; held until the next `err`.
- `ch_sub_clk_feq`, `ch_sub_clk_scl`, `ch_duty_cycle`, `ch_delay_set`  out  16*NUM_CH  active parameters; channel i occupies bits [16i+15:16i].
- `ch_rstn`  out  NUM_CH  per-channel active-low reset to the channel outputs.

## Operation
- States: IDLE, VALIDATE, HOLD, DONE, ERR.
- IDLE:
  - `wr_ready = commit_ready = 1`.
  - An accepted write updates the addressed shadow register at that edge. Writes to nonexistent channels are accepted and dropped.
  - An accepted commit latches the mask and enters VALIDATE.
  - A simultaneous write and commit: the write lands first, so validation sees the new value.
- VALIDATE: lasts exactly NUM_CH cycles. Index k = 0..NUM_CH-1 checks shadow channel k when `mask[k]` is set; unmasked indices pass. A channel passes when all of these hold:
  - feq ≠ 0
  - scl ≠ 0
  - scl ≥ feq
  - 17-bit `delay + duty` ≤ 16'hFFFF
- Any failure:
  - After the last index, go to ERR.
  - `err_ch` records the lowest failing k.
  - Active registers and `ch_rstn` are unchanged.
- All pass: go to HOLD.
  - On HOLD entry, `ch_rstn[k]` goes to 0 for masked k and the active registers load from shadow.
  - After HOLD_CYCLES cycles, go to DONE; `ch_rstn[k]` returns to 1 for masked k.
- DONE and ERR: one cycle each, pulsing `done` or `err`, then return to IDLE.
- Mask 0: validation passes trivially, no channel is touched, `done` still pulses.
- Unmasked channels never change `ch_rstn` or active values during a commit.
- Shadow registers are never modified by the sequencer.

## Timing
- Reset (async):
  - state IDLE; shadows and actives: feq=DEF_FEQ, scl=DEF_SCL, duty=0, delay=0.
  - `ch_rstn` = 0 for all channels. A channel stays in reset until its first successful commit.
  - `done` = `err` = `busy` = 0; `err_ch` = 0.
- Commit accepted at edge T:
  - VALIDATE occupies T+1..T+NUM_CH.
  - HOLD occupies NUM_CH+1 .. NUM_CH+HOLD_CYCLES cycles after T; `ch_rstn` low and new values visible from the first HOLD cycle.
  - DONE `done` pulse at T+NUM_CH+HOLD_CYCLES+1.
  - Failure: `err` pulse at T+NUM_CH+1.
- `busy` is high from T+1 until the DONE/ERR cycle inclusive.
- `wr_ready` and `commit_ready` are low whenever `busy` is high.
- All outputs are registered; no combinational path from inputs to outputs except `wr_ready`/`commit_ready`, which depend on state only.
- Reset mid-commit:
  - all state returns to reset values immediately;
  - the interrupted commit is lost and all channels are held in reset.

## Structure
- Package `ch_cfg_pkg`: state enum, register offsets (FEQ=0, SCL=1, DUTY=2, DELAY=3), 16-bit parameter typedef, `CLK_FEQ` = 50_000_000.
- Sub-module `ch_cfg_check`: combinational, 4×16-bit in, pass out; instantiated once and indexed by the VALIDATE counter.
- Shadow and active storage: register arrays in the top module.

## Test plan
- Reset, no commit -> all `ch_rstn` = 0; ch0 feq = 1000, scl = 10000; `busy` = 0.
- Write ch1 feq = 100, scl = 1000, duty = 3, delay = 2; commit mask 4'b0010 at T ->
  - `ch_rstn[1]` = 0 for 2 cycles starting T+5;
  - ch1 active values updated at T+5;
  - `done` at T+7;
  - `ch_rstn[0,2,3]` unchanged.
- Write ch2 scl = 50 (< feq 1000) and ch3 feq = 0; commit mask 4'b1100 ->
  - `err` at T+5 with `err_ch` = 2;
  - no active or `ch_rstn` change.
- Write and commit asserted in the same IDLE cycle -> committed value equals the new write.
- `wr_valid` held high during `busy` -> no shadow change until IDLE, then accepted.
- Commit mask 0 -> `done` at T+NUM_CH+HOLD_CYCLES+1; `rstn` pulse low mid-HOLD -> all outputs at reset values immediately.
